// File: rtl/fifo_wrapper_if.sv
// Data-path and register-bus signals of fifo_wrapper, bundled with
// producer/host-side (master) and FIFO-side (slave) views.
interface fifo_wrapper_if #(
    parameter int DW     = 8,
    parameter int REG_DW = 32,
    parameter int REG_AW = 8
);
    logic              reg_req;
    logic              reg_wr;
    logic [REG_AW-1:0] reg_addr;
    logic [REG_DW-1:0] reg_wdata;
    logic [REG_DW-1:0] reg_rdata;
    logic [DW-1:0]     din;
    logic              we;
    logic [DW-1:0]     dout;
    logic              re;
    logic              full;
    logic              empty;

    modport master (
        output reg_req, reg_wr, reg_addr, reg_wdata, din, we, re,
        input  reg_rdata, dout, full, empty
    );

    modport slave (
        input  reg_req, reg_wr, reg_addr, reg_wdata, din, we, re,
        output reg_rdata, dout, full, empty
    );
endinterface

// File: rtl/fifo_wrapper.sv
// Single-clock FIFO with a register block: enable/flush, almost-full
// threshold, sticky overflow/underflow flags and push/pop traffic counters.
module fifo_wrapper #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int REG_DW = 32,
    parameter int REG_AW = 8
) (
    input  logic           clk,
    input  logic           rst,
    fifo_wrapper_if.slave  bus
);
    localparam int DEPTH = 2**AW;
    localparam logic [REG_AW-1:0] A_CTRL   = REG_AW'('h00);
    localparam logic [REG_AW-1:0] A_STATUS = REG_AW'('h04);
    localparam logic [REG_AW-1:0] A_AFTH   = REG_AW'('h08);
    localparam logic [REG_AW-1:0] A_ERR    = REG_AW'('h0C);
    localparam logic [REG_AW-1:0] A_WCNT   = REG_AW'('h10);
    localparam logic [REG_AW-1:0] A_RCNT   = REG_AW'('h14);

    logic [DW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d, af_th_q, af_th_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic              en_q, en_d, ovf_q, ovf_d, udf_q, udf_d;
    logic [REG_DW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, rdata_q, rdata_d;

    logic reg_wen, reg_ren, flush, empty_w, full_w, push_ok, pop_ok, ovf_set, udf_set;
    logic [REG_DW-1:0] status;
    logic unused_wdata;

    assign reg_wen = bus.reg_req && bus.reg_wr;
    assign reg_ren = bus.reg_req && !bus.reg_wr;
    assign flush   = reg_wen && (bus.reg_addr == A_CTRL) && bus.reg_wdata[1];
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == (AW+1)'(DEPTH));

    // A flush owns the cycle: traffic is neither accepted nor flagged as an error.
    assign pop_ok  = bus.re && en_q && !empty_w && !flush;
    assign push_ok = bus.we && en_q && (!full_w || pop_ok) && !flush;
    assign ovf_set = bus.we && en_q && !flush && full_w && !pop_ok;
    assign udf_set = bus.re && en_q && !flush && empty_w;

    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.dout      = dout_q;
    assign bus.reg_rdata = rdata_q;
    assign unused_wdata  = ^bus.reg_wdata;

    always_comb begin
        status          = '0;
        status[0]       = empty_w;
        status[1]       = full_w;
        status[2]       = (count_q >= af_th_q);
        status[8+AW:8]  = count_q;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        wcnt_d  = wcnt_q + REG_DW'(push_ok);
        rcnt_d  = rcnt_q + REG_DW'(pop_ok);
        en_d    = en_q;
        af_th_d = af_th_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        rdata_d = rdata_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok) begin
                rptr_d = rptr_q + 1'b1;
                dout_d = mem_q[rptr_q];
            end
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end

        if (reg_wen) begin
            case (bus.reg_addr)
                A_CTRL: en_d    = bus.reg_wdata[0];
                A_AFTH: af_th_d = bus.reg_wdata[AW:0];
                A_ERR: begin
                    if (bus.reg_wdata[0]) ovf_d = 1'b0;
                    if (bus.reg_wdata[1]) udf_d = 1'b0;
                end
                default: ;
            endcase
        end
        // Applied after the clear so a new error wins over rw1c.
        if (ovf_set) ovf_d = 1'b1;
        if (udf_set) udf_d = 1'b1;

        if (reg_ren) begin
            case (bus.reg_addr)
                A_CTRL:   rdata_d = REG_DW'(en_q);
                A_STATUS: rdata_d = status;
                A_AFTH:   rdata_d = REG_DW'(af_th_q);
                A_ERR:    rdata_d = REG_DW'({udf_q, ovf_q});
                A_WCNT:   rdata_d = wcnt_q;
                A_RCNT:   rdata_d = rcnt_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wptr_q] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            en_q    <= 1'b1;
            af_th_q <= (AW+1)'(DEPTH-1);
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            af_th_q <= af_th_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_fifo_wrapper.sv
// Directed and random traffic against a queue-based model of the FIFO and its registers.
module tb_fifo_wrapper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wrapper_if #(.DW(8), .REG_DW(32), .REG_AW(8)) bus ();
    fifo_wrapper #(.DW(8), .AW(4), .REG_DW(32), .REG_AW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    logic        m_en;
    logic [4:0]  m_af;
    logic [1:0]  m_err;
    logic [31:0] m_wcnt, m_rcnt, m_rdata;
    logic [7:0]  m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] regval(input logic [7:0] a);
        logic [31:0] s;
        int n;
        n = q.size();
        s = (32'(n) << 8) | ((n >= int'(m_af)) ? 32'h4 : 32'h0)
          | ((n == 16) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
        case (a)
            8'h00:   return {31'b0, m_en};
            8'h04:   return s;
            8'h08:   return {27'b0, m_af};
            8'h0C:   return {30'b0, m_err};
            8'h10:   return m_wcnt;
            8'h14:   return m_rcnt;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 1'b1; m_af = 5'd15; m_err = 2'b0;
        m_wcnt = 0; m_rcnt = 0; m_rdata = 0; m_dout = 0;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic rq,
                       input logic rw, input logic [7:0] a, input logic [31:0] wd);
        logic flush, pop, push, ovf, udf;
        bus.we = w; bus.re = r; bus.din = d;
        bus.reg_req = rq; bus.reg_wr = rw; bus.reg_addr = a; bus.reg_wdata = wd;
        flush = rq && rw && (a == 8'h00) && wd[1];
        pop   = r && m_en && (q.size() != 0) && !flush;
        push  = w && m_en && !flush && ((q.size() < 16) || pop);
        ovf   = w && m_en && !flush && (q.size() == 16) && !pop;
        udf   = r && m_en && !flush && (q.size() == 0);
        if (rq && !rw) m_rdata = regval(a);
        @(posedge clk);
        if (pop) begin m_dout = q.pop_front(); m_rcnt++; end
        if (push) begin q.push_back(d); m_wcnt++; end
        if (flush) q.delete();
        if (rq && rw && a == 8'h0C) m_err = m_err & ~wd[1:0];
        m_err = m_err | {udf, ovf};
        if (rq && rw && a == 8'h00) m_en = wd[0];
        if (rq && rw && a == 8'h08) m_af = wd[4:0];
        #1;
        bus.we = 1'b0; bus.re = 1'b0; bus.reg_req = 1'b0; bus.reg_wr = 1'b0;
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("full", 32'(bus.full), (q.size() == 16) ? 32'd1 : 32'd0);
        chk("empty", 32'(bus.empty), (q.size() == 0) ? 32'd1 : 32'd0);
        chk("rdata", bus.reg_rdata, m_rdata);
    endtask

    task automatic idle();                   cyc(0, 0, 8'h0, 0, 0, 8'h0, 32'h0); endtask
    task automatic push(input logic [7:0] d); cyc(1, 0, d, 0, 0, 8'h0, 32'h0);   endtask
    task automatic pop();                    cyc(0, 1, 8'h0, 0, 0, 8'h0, 32'h0); endtask
    task automatic wreg(input logic [7:0] a, input logic [31:0] v); cyc(0, 0, 8'h0, 1, 1, a, v); endtask
    task automatic rreg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cyc(0, 0, 8'h0, 1, 0, a, 32'h0);
        chk(tag, bus.reg_rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.we = 0; bus.re = 0; bus.din = 0;
        bus.reg_req = 0; bus.reg_wr = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_rdata", bus.reg_rdata, 32'h0);
    endtask

    initial begin
        logic [7:0]  addrs [8];
        logic [31:0] wsave;
        int op;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h02};
        model_reset();
        do_reset();

        rreg("status_rst", 8'h04, 32'h1);
        rreg("ctrl_rst", 8'h00, 32'h1);
        rreg("afth_rst", 8'h08, 32'd15);

        for (int i = 0; i < 16; i++) push(8'(i + 1));
        chk("full_16", 32'(bus.full), 32'h1);
        rreg("status_full", 8'h04, 32'h1006);
        push(8'hAA);
        rreg("err_ovf", 8'h0C, 32'h1);
        for (int i = 0; i < 16; i++) begin
            pop();
            chk("pop_order", 32'(bus.dout), 32'(i + 1));
        end
        chk("empty_after", 32'(bus.empty), 32'h1);
        rreg("rcnt16", 8'h14, 32'd16);

        wreg(8'h0C, 32'h3);
        cyc(1, 1, 8'h5A, 0, 0, 8'h0, 32'h0);
        rreg("err_udf", 8'h0C, 32'h2);
        rreg("status_cnt1", 8'h04, 32'h100);
        pop();
        chk("pop_5a", 32'(bus.dout), 32'h5A);
        wreg(8'h0C, 32'h3);

        for (int i = 0; i < 16; i++) push(8'($urandom));
        for (int i = 0; i < 20; i++) cyc(1, 1, 8'($urandom), 0, 0, 8'h0, 32'h0);
        rreg("status_wrap", 8'h04, 32'h1006);
        rreg("err_none", 8'h0C, 32'h0);
        wreg(8'h00, 32'h3);

        wreg(8'h08, 32'd4);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        rreg("status_af", 8'h04, 32'h404);
        cyc(0, 0, 8'h0, 1, 0, 8'h10, 32'h0);
        wsave = bus.reg_rdata;
        wreg(8'h00, 32'h3);
        rreg("status_flush", 8'h04, 32'h1);
        rreg("ctrl_en", 8'h00, 32'h1);
        rreg("wcnt_keep", 8'h10, wsave);

        push(8'h11);
        wreg(8'h00, 32'h0);
        for (int i = 0; i < 8; i++) cyc(1'($urandom), 1'($urandom), 8'($urandom), 0, 0, 8'h0, 32'h0);
        rreg("status_dis", 8'h04, 32'h100);
        rreg("err_dis", 8'h0C, 32'h0);
        wreg(8'h00, 32'h1);
        pop();
        chk("pop_11", 32'(bus.dout), 32'h11);

        cyc(0, 1, 8'h0, 1, 1, 8'h0C, 32'h3);
        rreg("err_setwins", 8'h0C, 32'h2);
        wreg(8'h0C, 32'h3);
        rreg("err_clr", 8'h0C, 32'h0);
        rreg("unmapped", 8'h18, 32'h0);

        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 15);
            if (op < 11)
                cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom),
                    0, 0, 8'h0, 32'h0);
            else if (op < 14)
                cyc(1'($urandom), 1'($urandom), 8'($urandom), 1, 0,
                    addrs[$urandom_range(0, 7)], 32'h0);
            else if (op == 14)
                cyc(1'($urandom), 1'($urandom), 8'($urandom), 1, 1,
                    ($urandom_range(0, 1) != 0) ? 8'h0C : 8'h08, 32'($urandom_range(0, 31)));
            else
                cyc(1'($urandom), 1'($urandom), 8'($urandom), 1, 1, 8'h00,
                    {30'b0, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) != 0)});
        end

        wreg(8'h00, 32'h1);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        do_reset();
        rreg("status_rst2", 8'h04, 32'h1);
        rreg("wcnt_rst2", 8'h10, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
